regfile_wb_sched: RTL and testbench

- Schedules the single register-file write port between two writeback requesters: the ALU pipe and the variable-latency load/memory pipe.
- Keeps a per-register pending scoreboard so the issue stage stalls on RAW and WAW hazards until the producing write has committed.
- Sits between the execute/memory stages and the regfile. It drives the regfile's rd_addr, write_data and enable inputs directly.

---
 rtl/brisc_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_wb_sched.sv | 122 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared core types and constants.
// Sizes the register file and names the writeback sources.
package brisc_pkg;

  localparam int XLEN       = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_BITS   = $clog2(REG_NUM);
  localparam int STARVE_DEF = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Ports: set/clr strobes+addr in; rs1/rs2/rd/wr probe in; pending, hazard out.
module regfile_scoreboard
  import brisc_pkg::*;
#(
  parameter int REG_NUM = brisc_pkg::REG_NUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [REG_BITS-1:0] set_addr,
  input  logic                clr_en,
  input  logic [REG_BITS-1:0] clr_addr,
  input  logic [REG_BITS-1:0] rs1,
  input  logic [REG_BITS-1:0] rs2,
  input  logic [REG_BITS-1:0] rd,
  input  logic                wr,
  output logic [REG_NUM-1:0]  pending,
  output logic                hazard
);

  logic [REG_NUM-1:0] pending_nxt;

  // Clear first so a same-edge set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hazard = pending[rs1]
                | pending[rs2]
                | (wr & pending[rd]);

endmodule

// File: rtl/regfile_wb_sched.sv
// Arbitrates the regfile write port between ALU and memory writeback.
// Ports: issue probe/stall, alu_wb_*/mem_wb_* handshakes, rf_* write, pending.
module regfile_wb_sched
  import brisc_pkg::*;
#(
  parameter int XLEN         = brisc_pkg::XLEN,
  parameter int REG_NUM      = brisc_pkg::REG_NUM,
  parameter int STARVE_LIMIT = brisc_pkg::STARVE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [REG_BITS-1:0] issue_rs1,
  input  logic [REG_BITS-1:0] issue_rs2,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic                issue_wr,
  output logic                issue_stall,
  input  logic                alu_wb_valid,
  input  logic [REG_BITS-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]     alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                mem_wb_valid,
  input  logic [REG_BITS-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]     mem_wb_data,
  output logic                mem_wb_ready,
  output logic [REG_BITS-1:0] rf_rd_addr,
  output logic [XLEN-1:0]     rf_write_data,
  output logic                rf_enable,
  output logic [REG_NUM-1:0]  pending
);

  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX =
    CNT_BITS'(STARVE_LIMIT);

  logic [CNT_BITS-1:0] starve_cnt;
  wb_src_e             src;
  logic [REG_BITS-1:0] wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                wb_en;
  logic                hazard;
  logic                fire;

  // Memory wins unless the ALU has lost STARVE_LIMIT times in a row.
  always_comb begin
    src = WB_NONE;
    if (reset) begin
      if (alu_wb_valid &&
          (!mem_wb_valid || starve_cnt == CNT_MAX))
        src = WB_ALU;
      else if (mem_wb_valid)
        src = WB_MEM;
    end
  end

  assign alu_wb_ready = (src == WB_ALU);
  assign mem_wb_ready = (src == WB_MEM);

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    unique case (1'b1)
      alu_wb_ready: begin
        wb_rd   = alu_wb_rd;
        wb_data = alu_wb_data;
      end
      mem_wb_ready: begin
        wb_rd   = mem_wb_rd;
        wb_data = mem_wb_data;
      end
      default: ;
    endcase
  end

  // x0 writes finish the handshake but never reach the regfile.
  assign wb_en = (src != WB_NONE) && (wb_rd != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_enable     <= 1'b0;
      rf_rd_addr    <= '0;
      rf_write_data <= '0;
      starve_cnt    <= '0;
    end else begin
      rf_enable <= wb_en;
      if (wb_en) begin
        rf_rd_addr    <= wb_rd;
        rf_write_data <= wb_data;
      end
      if (alu_wb_valid && !alu_wb_ready)
        starve_cnt <= (starve_cnt == CNT_MAX) ?
                      starve_cnt :
                      starve_cnt + CNT_BITS'(1);
      else
        starve_cnt <= '0;
    end
  end

  // Stall is forced high in reset so nothing issues into a dead pipe.
  assign issue_stall = !reset || (issue_valid && hazard);

  assign fire = issue_valid && !issue_stall &&
                issue_wr && (issue_rd != '0);

  regfile_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (fire),
    .set_addr (issue_rd),
    .clr_en   (rf_enable),
    .clr_addr (rf_rd_addr),
    .rs1      (issue_rs1),
    .rs2      (issue_rs2),
    .rd       (issue_rd),
    .wr       (issue_wr),
    .pending  (pending),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench with write scoreboard and reference model.
// Drives on negedge, checks comb outputs +1 and regs after posedge.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, iw;
  logic [4:0]  rs1, rs2, ird;
  logic        stall;
  logic        av, mv;
  logic [4:0]  ard, mrd;
  logic [31:0] adata, mdata;
  logic        ardy, mrdy;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_en;
  logic [31:0] pend;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] m_pend;
  int          m_sc;
  logic        m_en;
  logic [4:0]  m_addr;
  logic        last_alu, last_mem, last_stall;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk           (clk),
    .reset         (rst),
    .issue_valid   (iv),
    .issue_rs1     (rs1),
    .issue_rs2     (rs2),
    .issue_rd      (ird),
    .issue_wr      (iw),
    .issue_stall   (stall),
    .alu_wb_valid  (av),
    .alu_wb_rd     (ard),
    .alu_wb_data   (adata),
    .alu_wb_ready  (ardy),
    .mem_wb_valid  (mv),
    .mem_wb_rd     (mrd),
    .mem_wb_data   (mdata),
    .mem_wb_ready  (mrdy),
    .rf_rd_addr    (rf_addr),
    .rf_write_data (rf_data),
    .rf_enable     (rf_en),
    .pending       (pend)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    logic ag, mg, stall_m, fire_m, pushed;
    wr_t  w;
    ag = 1'b0;
    mg = 1'b0;
    stall_m = 1'b1;
    pushed = 1'b0;
    #1;
    if (rst) begin
      ag = av && (!mv || m_sc == 4);
      mg = mv && !ag;
      stall_m = iv && (m_pend[rs1] || m_pend[rs2] ||
                       (iw && m_pend[ird]));
    end
    chk("alu_ready", {31'b0, ardy}, {31'b0, ag});
    chk("mem_ready", {31'b0, mrdy}, {31'b0, mg});
    chk("stall", {31'b0, stall}, {31'b0, stall_m});
    last_alu   = ardy;
    last_mem   = mrdy;
    last_stall = stall;
    if (ag || mg) begin
      w.addr = ag ? ard : mrd;
      w.data = ag ? adata : mdata;
      if (w.addr != 5'd0) begin
        exp_q.push_back(w);
        pushed = 1'b1;
      end
    end
    fire_m = rst && iv && !stall_m && iw && (ird != 5'd0);
    @(posedge clk);
    #1;
    if (!rst) begin
      m_pend = '0;
      m_sc   = 0;
      m_en   = 1'b0;
      m_addr = '0;
      exp_q.delete();
    end else begin
      m_sc = (av && !ag) ? ((m_sc == 4) ? 4 : m_sc + 1) : 0;
      if (m_en) m_pend[m_addr] = 1'b0;
      if (fire_m) m_pend[ird] = 1'b1;
      m_pend[0] = 1'b0;
      m_en = pushed;
      if (pushed) m_addr = w.addr;
    end
    chk("rf_enable", {31'b0, rf_en}, {31'b0, m_en});
    if (m_en && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("rf_addr", {27'b0, rf_addr}, {27'b0, w.addr});
      chk("rf_data", rf_data, w.data);
    end
    chk("pending", pend, m_pend);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    iv = 1'b0; iw = 1'b0;
    rs1 = '0; rs2 = '0; ird = '0;
    av = 1'b1; ard = 5'd3; adata = 32'h1;
    mv = 1'b1; mrd = 5'd4; mdata = 32'h2;
    m_pend = '0; m_sc = 0; m_en = 1'b0; m_addr = '0;
    @(negedge clk);

    // reset held with both requesters active
    step();
    step();
    chk("rst_pend", pend, 32'h0);
    chk("rst_en", {31'b0, rf_en}, 32'h0);

    // RAW hazard on x5
    rst = 1'b1;
    av = 1'b0; mv = 1'b0;
    iv = 1'b1; iw = 1'b1; ird = 5'd5;
    step();
    chk("raw_set", {31'b0, pend[5]}, 32'h1);
    iw = 1'b0; ird = 5'd0; rs1 = 5'd5;
    av = 1'b1; ard = 5'd5; adata = 32'hDEAD_BEEF;
    step();
    chk("raw_stall", {31'b0, last_stall}, 32'h1);
    chk("raw_grant", {31'b0, last_alu}, 32'h1);
    chk("raw_wr_data", rf_data, 32'hDEAD_BEEF);
    av = 1'b0;
    step();
    chk("raw_hold", {31'b0, last_stall}, 32'h1);
    step();
    chk("raw_release", {31'b0, last_stall}, 32'h0);
    iv = 1'b0; rs1 = '0;

    // sustained contention: mem x4 then alu x1
    av = 1'b1; ard = 5'd11; adata = 32'hA11;
    mv = 1'b1; mrd = 5'd12; mdata = 32'h100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("cont_alu", {31'b0, last_alu},
          (i % 5 == 4) ? 32'h1 : 32'h0);
      if (last_mem) mdata = mdata + 32'h1;
    end
    av = 1'b0; mv = 1'b0;
    step();

    // x0 write: handshake only
    mv = 1'b1; mrd = 5'd0; mdata = 32'h1234;
    step();
    chk("x0_ready", {31'b0, last_mem}, 32'h1);
    chk("x0_noen", {31'b0, rf_en}, 32'h0);
    chk("x0_pend", pend, 32'h0);
    mv = 1'b0;

    // commit of x7 coincides with new issue to x7
    av = 1'b1; ard = 5'd7; adata = 32'h77;
    step();
    av = 1'b0;
    iv = 1'b1; iw = 1'b1; ird = 5'd7;
    step();
    chk("same_edge_en", {31'b0, last_stall}, 32'h0);
    chk("same_edge_set", {31'b0, pend[7]}, 32'h1);
    step();
    chk("waw_stall", {31'b0, last_stall}, 32'h1);
    iv = 1'b0; iw = 1'b0; ird = '0;

    // reset with a write in flight
    av = 1'b1; ard = 5'd9; adata = 32'h99;
    step();
    chk("mid_grant", {31'b0, last_alu}, 32'h1);
    rst = 1'b0;
    step();
    chk("mid_en", {31'b0, rf_en}, 32'h0);
    chk("mid_pend", pend, 32'h0);
    rst = 1'b1; av = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
